id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the 32-bit processor. It sits directly downstream of the register file and captures its combinational read_rs/read_rt outputs on the rising clock edge. At capture it selects the freshest value of each source operand, choosing among the result of the instruction currently in EX, the MEM-stage result, and the register file. It also detects load-use hazards, inserts bubbles, honours downstream back-pressure and flush, and keeps a saturating stall counter.

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubbles,
// back-pressure hold, flush squash and a saturating stall counter.
module id_ex_stage #(
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [31:0]       id_read_rs,
   input  logic [31:0]       id_read_rt,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_is_load,
   input  logic              id_we,
   input  logic [31:0]       ex_result,
   input  logic              mem_we,
   input  logic [4:0]        mem_rd,
   input  logic [31:0]       mem_result,
   input  logic              ex_ready,
   input  logic              flush,
   output logic              id_stall,
   output logic              ex_valid,
   output logic              ex_is_load,
   output logic              ex_we,
   output logic [4:0]        ex_rd,
   output logic [31:0]       ex_rs_val,
   output logic [31:0]       ex_rt_val,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  stall_count
);

   logic        match_rs;
   logic        match_rt;
   logic        ex_fwd_ok;
   logic        luse;
   logic        adv;
   logic        bubble;
   logic [31:0] rs_sel;
   logic [31:0] rt_sel;

   assign match_rs = id_valid & id_uses_rs & (id_rs != 5'd0);
   assign match_rt = id_valid & id_uses_rt & (id_rt != 5'd0);

   assign luse = ex_valid & ex_is_load & ex_we &
                 ((match_rs & (ex_rd == id_rs)) |
                  (match_rt & (ex_rd == id_rt)));

   // A load in EX has no data yet; only ALU results may be forwarded.
   assign ex_fwd_ok = ex_valid & ex_we & ~ex_is_load;

   always_comb begin
      rs_sel = id_read_rs;
      if (id_rs == 5'd0)
         rs_sel = 32'd0;
      else if (ex_fwd_ok && ex_rd == id_rs)
         rs_sel = ex_result;
      else if (mem_we && mem_rd == id_rs)
         rs_sel = mem_result;
   end

   always_comb begin
      rt_sel = id_read_rt;
      if (id_rt == 5'd0)
         rt_sel = 32'd0;
      else if (ex_fwd_ok && ex_rd == id_rt)
         rt_sel = ex_result;
      else if (mem_we && mem_rd == id_rt)
         rt_sel = mem_result;
   end

   assign adv      = ex_ready;
   assign bubble   = flush | luse | ~id_valid;
   assign id_stall = ~flush & (~ex_ready | luse);

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid   <= 1'b0;
         ex_is_load <= 1'b0;
         ex_we      <= 1'b0;
         ex_rd      <= 5'd0;
         ex_rs_val  <= 32'd0;
         ex_rt_val  <= 32'd0;
         ex_imm     <= 32'd0;
         ex_ctrl    <= '0;
      end else if (adv) begin
         if (bubble) begin
            ex_valid   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_we      <= 1'b0;
            ex_rd      <= 5'd0;
            ex_rs_val  <= 32'd0;
            ex_rt_val  <= 32'd0;
            ex_imm     <= 32'd0;
            ex_ctrl    <= '0;
         end else begin
            ex_valid   <= 1'b1;
            ex_is_load <= id_is_load;
            ex_we      <= id_we;
            ex_rd      <= id_rd;
            ex_rs_val  <= rs_sel;
            ex_rt_val  <= rt_sel;
            ex_imm     <= id_imm;
            ex_ctrl    <= id_ctrl;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (id_stall && stall_count != {CNT_W{1'b1}})
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus
// randomized traffic against a behavioural pipeline-register model.
module tb_id_ex_stage;

   localparam int CTRL_W = 12;
   localparam int CNT_W  = 16;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic [4:0]        id_rs, id_rt, id_rd;
   logic              id_uses_rs, id_uses_rt;
   logic [31:0]       id_read_rs, id_read_rt, id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_is_load, id_we;
   logic [31:0]       ex_result;
   logic              mem_we;
   logic [4:0]        mem_rd;
   logic [31:0]       mem_result;
   logic              ex_ready, flush;
   logic              id_stall;
   logic              ex_valid, ex_is_load, ex_we;
   logic [4:0]        ex_rd;
   logic [31:0]       ex_rs_val, ex_rt_val, ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [CNT_W-1:0]  stall_count;

   id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_read_rs(id_read_rs), .id_read_rt(id_read_rt),
      .id_imm(id_imm), .id_ctrl(id_ctrl),
      .id_is_load(id_is_load), .id_we(id_we),
      .ex_result(ex_result), .mem_we(mem_we), .mem_rd(mem_rd),
      .mem_result(mem_result), .ex_ready(ex_ready), .flush(flush),
      .id_stall(id_stall), .ex_valid(ex_valid),
      .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_rd(ex_rd),
      .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model of what EX currently holds
   bit         m_valid, m_load, m_we;
   int         m_rd;
   bit  [31:0] m_rs, m_rt, m_imm;
   bit  [11:0] m_ctrl;
   int         m_cnt;

   function automatic bit [31:0] freshest(input int s, input bit [31:0] rf);
      if (s == 0) return 0;
      if (m_valid && m_we && !m_load && m_rd == s) return ex_result;
      if (mem_we && mem_rd == s) return mem_result;
      return rf;
   endfunction

   function automatic bit waits_on_load();
      bit a, b;
      if (!(m_valid && m_load && m_we)) return 0;
      a = id_valid && id_uses_rs && id_rs != 0 && m_rd == id_rs;
      b = id_valid && id_uses_rt && id_rt != 0 && m_rd == id_rt;
      return a || b;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_load = 0; m_we = 0; m_rd = 0;
      m_rs = 0; m_rt = 0; m_imm = 0; m_ctrl = 0;
   endtask

   task automatic set_idle();
      reset = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_read_rs = 0;
      id_read_rt = 0; id_imm = 0; id_ctrl = 0; id_is_load = 0;
      id_we = 0; ex_result = 0; mem_we = 0; mem_rd = 0;
      mem_result = 0; ex_ready = 1; flush = 0;
   endtask

   task automatic check_outs(input string ph);
      chk({ph, "_valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
      chk({ph, "_load"}, {31'd0, ex_is_load}, {31'd0, m_load});
      chk({ph, "_we"}, {31'd0, ex_we}, {31'd0, m_we});
      chk({ph, "_rd"}, {27'd0, ex_rd}, m_rd);
      chk({ph, "_rs"}, ex_rs_val, m_rs);
      chk({ph, "_rt"}, ex_rt_val, m_rt);
      chk({ph, "_imm"}, ex_imm, m_imm);
      chk({ph, "_ctrl"}, {20'd0, ex_ctrl}, {20'd0, m_ctrl});
      chk({ph, "_cnt"}, {16'd0, stall_count}, m_cnt);
   endtask

   // Inputs are set after a negedge; evaluate, clock, compare, return
   // at the next negedge.
   task automatic step(input string ph);
      bit stall_exp, lu;
      bit [31:0] nrs, nrt;
      #1;
      lu = waits_on_load();
      stall_exp = !flush && (!ex_ready || lu);
      chk({ph, "_stall"}, {31'd0, id_stall}, {31'd0, stall_exp});
      nrs = freshest(id_rs, id_read_rs);
      nrt = freshest(id_rt, id_read_rt);
      if (reset) begin
         model_clear();
         m_cnt = 0;
      end else begin
         if (stall_exp && m_cnt < CMAX) m_cnt++;
         if (ex_ready) begin
            if (flush || lu || !id_valid) begin
               model_clear();
            end else begin
               m_valid = 1; m_load = id_is_load; m_we = id_we;
               m_rd = id_rd; m_rs = nrs; m_rt = nrt;
               m_imm = id_imm; m_ctrl = id_ctrl;
            end
         end
      end
      @(posedge clk);
      #1;
      check_outs(ph);
      @(negedge clk);
   endtask

   task automatic load_instr(input int rs, input int rt, input int rd,
                             input bit [31:0] vrs, input bit [31:0] vrt);
      id_valid = 1; id_rs = rs[4:0]; id_rt = rt[4:0]; id_rd = rd[4:0];
      id_uses_rs = 1; id_uses_rt = 1;
      id_read_rs = vrs; id_read_rt = vrt; id_we = 1; id_is_load = 0;
      id_imm = 32'h0000_0100; id_ctrl = 12'h5A3;
   endtask

   initial begin
      model_clear();
      m_cnt = 0;
      set_idle();
      @(negedge clk);
      reset = 1;
      step("rst");
      chk("rst_valid_c", {31'd0, ex_valid}, 32'd0);
      chk("rst_cnt_c", {16'd0, stall_count}, 32'd0);
      reset = 0;

      // plain capture
      load_instr(3, 4, 9, 32'h11, 32'h22);
      step("t1");
      chk("t1_rs_c", ex_rs_val, 32'h11);
      chk("t1_rt_c", ex_rt_val, 32'h22);

      // EX forward: EX holds rd=9 ALU op; now rd=5
      load_instr(1, 2, 5, 32'h1, 32'h2);
      step("t2a");
      load_instr(5, 0, 6, 32'h0, 32'h77);
      ex_result = 32'hDEAD;
      step("t2b");
      chk("t2_fwd_c", ex_rs_val, 32'hDEAD);
      chk("t2_r0_c", ex_rt_val, 32'h0);

      // priority: EX holds rd=6; MEM also rd=6
      load_instr(0, 6, 8, 32'h0, 32'h99);
      ex_result = 32'hA; mem_we = 1; mem_rd = 6; mem_result = 32'hB;
      step("t3a");
      chk("t3_ex_c", ex_rt_val, 32'hA);
      // EX now holds rd=8: MEM wins
      load_instr(0, 6, 10, 32'h0, 32'h99);
      step("t3b");
      chk("t3_mem_c", ex_rt_val, 32'hB);
      set_idle();

      // load-use
      reset = 1;
      step("t4r");
      reset = 0;
      load_instr(1, 2, 7, 32'h4, 32'h8);
      id_is_load = 1;
      step("t4ld");
      load_instr(0, 7, 11, 32'h0, 32'h0);
      #1;
      chk("t4_stall_c", {31'd0, id_stall}, 32'd1);
      step("t4st");
      chk("t4_bub_c", {31'd0, ex_valid}, 32'd0);
      mem_we = 1; mem_rd = 7; mem_result = 32'h55;
      step("t4fw");
      chk("t4_rt_c", ex_rt_val, 32'h55);
      chk("t4_cnt_c", {16'd0, stall_count}, 32'd1);
      mem_we = 0;

      // back-pressure then flush
      load_instr(2, 3, 12, 32'h3, 32'h4);
      ex_ready = 0;
      repeat (3) step("t5bp");
      chk("t5_cnt_c", {16'd0, stall_count}, 32'd4);
      chk("t5_hold_c", ex_rt_val, 32'h55);
      ex_ready = 1; flush = 1;
      #1;
      chk("t5_nostall_c", {31'd0, id_stall}, 32'd0);
      step("t5fl");
      chk("t5_flush_c", {31'd0, ex_valid}, 32'd0);
      flush = 0;

      // build ex_valid=1, count=9 then reset
      step("t6cap");
      ex_ready = 0;
      repeat (5) step("t6bp");
      chk("t6_pre_c", {16'd0, stall_count}, 32'd9);
      reset = 1;
      step("t6rst");
      chk("t6_valid_c", {31'd0, ex_valid}, 32'd0);
      chk("t6_cnt_c", {16'd0, stall_count}, 32'd0);
      chk("t6_rs_c", ex_rs_val, 32'd0);
      ex_ready = 1;

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         reset      = ($urandom_range(0, 99) < 2);
         id_valid   = ($urandom_range(0, 9) < 8);
         id_rs      = 5'($urandom_range(0, 7));
         id_rt      = 5'($urandom_range(0, 7));
         id_rd      = 5'($urandom_range(0, 7));
         id_uses_rs = $urandom_range(0, 1) == 1;
         id_uses_rt = $urandom_range(0, 1) == 1;
         id_read_rs = $urandom;
         id_read_rt = $urandom;
         id_imm     = $urandom;
         id_ctrl    = 12'($urandom);
         id_is_load = ($urandom_range(0, 3) == 0);
         id_we      = ($urandom_range(0, 9) < 8);
         ex_result  = $urandom;
         mem_we     = $urandom_range(0, 1) == 1;
         mem_rd     = 5'($urandom_range(0, 7));
         mem_result = $urandom;
         ex_ready   = ($urandom_range(0, 9) < 8);
         flush      = ($urandom_range(0, 9) == 0);
         step("rnd");
      end

      // saturation
      set_idle();
      reset = 1;
      step("satr");
      reset = 0;
      ex_ready = 0;
      repeat (CMAX + 10) @(posedge clk);
      #1;
      chk("sat_cnt", {16'd0, stall_count}, 32'h0000_FFFF);
      chk("sat_valid", {31'd0, ex_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
